// File: rtl/gal_pkg.sv
// gal_pkg: shared macrocell configuration constants for the OLMC bank
package gal_pkg;
  localparam int CELL_CFG_W = 2;
  localparam int S0_IDX = 0;
  localparam int S1_IDX = 1;
  typedef enum logic {MODE_REG = 1'b0, MODE_COMB = 1'b1} mode_e;
  typedef enum logic {POL_LOW = 1'b0, POL_HIGH = 1'b1} pol_e;
endpackage

// File: rtl/gal_olmc.sv
// gal_olmc: one output logic macrocell with register, polarity, mode and feedback muxes
module gal_olmc
  import gal_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sp,
  input  logic                  i_hold,
  input  logic [CELL_CFG_W-1:0] i_cfg,
  input  logic                  i_sop,
  input  logic                  i_oe,
  input  logic                  i_pin,
  output logic                  o_y,
  output logic                  o_ye,
  output logic                  o_fb
);
  logic r_q;
  logic w_comb;
  logic w_src;
  assign w_comb = mode_e'(i_cfg[S1_IDX]) == MODE_COMB;
  // cell register clocks in both modes; frozen while configuration is in flight
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_q <= 1'b0;
    else if (!i_hold) r_q <= i_sp | i_sop;
  assign w_src = w_comb ? i_sop : r_q;
  assign o_y   = (pol_e'(i_cfg[S0_IDX]) == POL_HIGH) ? w_src : ~w_src;
  assign o_ye  = i_oe & ~i_hold & i_rst_n;
  assign o_fb  = w_comb ? (o_ye ? o_y : i_pin) : r_q;
endmodule

// File: rtl/gal_olmc_bank.sv
// gal_olmc_bank: GAL22V10-style OLMC bank with serial architecture-bit chain
module gal_olmc_bank
  import gal_pkg::*;
#(
  parameter int N     = 10,
  parameter int CNT_W = $clog2(2*N+2)
) (
  input  logic         C,
  input  logic         RN,
  input  logic         SP,
  input  logic [N-1:0] SOP,
  input  logic [N-1:0] OE,
  input  logic [N-1:0] PIN_IN,
  input  logic         CFG_EN,
  input  logic         CFG_SI,
  output logic         CFG_SO,
  output logic         CFG_ERR,
  output logic [N-1:0] Y,
  output logic [N-1:0] YE,
  output logic [N-1:0] FB
);
  localparam int CW = CELL_CFG_W*N;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CW);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CW+1);
  logic [CW-1:0]    r_cfg_sh;
  logic [CW-1:0]    r_cfg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cfg_en_q;
  logic             r_cfg_err;
  logic             w_hold;
  assign w_hold  = CFG_EN | r_cfg_en_q;
  assign CFG_SO  = r_cfg_sh[CW-1];
  assign CFG_ERR = r_cfg_err;
  // shift chain and bit count while enabled; commit or flag a bad count when enable falls
  always_ff @(posedge C or negedge RN)
    if (!RN) begin
      r_cfg_sh   <= '0;
      r_cfg      <= '0;
      r_cnt      <= '0;
      r_cfg_en_q <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_en_q <= CFG_EN;
      if (CFG_EN) begin
        r_cfg_sh <= {r_cfg_sh[CW-2:0], CFG_SI};
        r_cnt    <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
      end else if (r_cfg_en_q) begin
        if (r_cnt == CNT_FULL) r_cfg <= r_cfg_sh;
        r_cfg_err <= r_cnt != CNT_FULL;
        r_cnt     <= '0;
      end
    end
  for (genvar i = 0; i < N; i++) begin : g_cell
    gal_olmc u_cell (
      .i_clk   (C),
      .i_rst_n (RN),
      .i_sp    (SP),
      .i_hold  (w_hold),
      .i_cfg   (r_cfg[CELL_CFG_W*i +: CELL_CFG_W]),
      .i_sop   (SOP[i]),
      .i_oe    (OE[i]),
      .i_pin   (PIN_IN[i]),
      .o_y     (Y[i]),
      .o_ye    (YE[i]),
      .o_fb    (FB[i])
    );
  end
endmodule
